axi_marker_insert: RTL and testbench

Inserts a one-beat marker (sync) word at the start of every packet of an AXI-stream. The marker inserter sits on the transmit side of a link; the matching detector on the receive side, axi_pipeline_equal, runs with cmp equal to the same marker value. Payload passes through a single registered output stage at full throughput, and each inserted marker costs one cycle of input back-pressure. The stream packs tlast into the MSB of the user field, matching the detector's convention.

---
 rtl/rwt_axis_pkg.sv | 24 ++
 rtl/axi_reg_slice.sv | 48 ++++
 rtl/axi_marker_insert.sv | 109 ++++++++++
 tb/tb_axi_marker_insert.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rwt_axis_pkg.sv
// -----------------------------------------------------------------------------
// rwt_axis_pkg
// Shared types and helpers for the AXI-stream blocks that pack tlast into the
// MSB of the user field.
//   marker_state_t : packet-framing state (ST_IDLE = expecting first beat)
//   user_last()    : extracts tlast (MSB) from a user field of given width
// -----------------------------------------------------------------------------
package rwt_axis_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_BODY
    } marker_state_t;

    // The user field is zero-extended into 32 bits so one helper serves any
    // UWIDTH up to 32; the MSB of the original field is tlast.
    function automatic logic user_last(input logic [31:0] user,
                                       input int unsigned uwidth);
        logic [31:0] sh;
        sh = user >> (uwidth - 1);
        return sh[0];
    endfunction

endpackage

// File: rtl/axi_reg_slice.sv
// -----------------------------------------------------------------------------
// axi_reg_slice
// Single-entry registered output slot for a valid/ready stream. The slot loads
// whenever it is free (empty or draining this cycle) and a beat is offered, so
// a drain and a reload on the same edge produce no bubble.
// Ports:
//   clk, aresetn      : clock, asynchronous active-low reset
//   in_valid          : a beat is available to load
//   in_payload        : beat contents (WIDTH bits)
//   slot_free         : slot will accept a load on this edge
//   out_valid/out_payload/out_ready : registered downstream handshake
// -----------------------------------------------------------------------------
module axi_reg_slice #(
    parameter int WIDTH = 73
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_payload,
    output logic             slot_free,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_payload,
    input  logic             out_ready
);

    logic             vld_p1;
    logic [WIDTH-1:0] pay_p1;

    assign slot_free = !vld_p1 || out_ready;

    // Stage p1: output slot. Payload only changes on a load, so a stalled beat
    // stays stable until it is taken.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_p1 <= 1'b0;
            pay_p1 <= '0;
        end else if (slot_free) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                pay_p1 <= in_payload;
            end
        end
    end

    assign out_valid   = vld_p1;
    assign out_payload = pay_p1;

endmodule

// File: rtl/axi_marker_insert.sv
// -----------------------------------------------------------------------------
// axi_marker_insert
// Inserts a one-beat marker word ahead of every packet of an AXI-stream whose
// tlast lives in the MSB of the user field. Payload passes through a single
// registered slot at full rate; each marker costs one input stall cycle.
// Ports:
//   clk, aresetn               : clock, asynchronous active-low reset
//   enable                     : insertion enable, sampled at packet start
//   marker, marker_user        : marker data and sideband (marker never last)
//   s_axi_valid/ready/data/user: input stream
//   m_axi_valid/ready/data/user: output stream
//   marker_count               : markers emitted, wraps at 2^32
// -----------------------------------------------------------------------------
module axi_marker_insert
    import rwt_axis_pkg::*;
#(
    parameter int DWIDTH = 64,
    parameter int UWIDTH = 9
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic [DWIDTH-1:0] marker,
    input  logic [UWIDTH-2:0] marker_user,
    input  logic              s_axi_valid,
    output logic              s_axi_ready,
    input  logic [DWIDTH-1:0] s_axi_data,
    input  logic [UWIDTH-1:0] s_axi_user,
    output logic              m_axi_valid,
    input  logic              m_axi_ready,
    output logic [DWIDTH-1:0] m_axi_data,
    output logic [UWIDTH-1:0] m_axi_user,
    output logic [31:0]       marker_count
);

    localparam int PW = DWIDTH + UWIDTH;

    marker_state_t     state, state_next;
    logic              slot_free;
    logic              insert_mode;
    logic              marker_load;
    logic              beat_accept;
    logic [DWIDTH-1:0] mux_data;
    logic [UWIDTH-1:0] mux_user;
    logic [PW-1:0]     slot_payload;

    // In ST_IDLE with enable set, the slot is fed the marker instead of the
    // input beat; the input stays stalled until the next cycle.
    assign insert_mode = (state == ST_IDLE) && enable;

    // Gated by aresetn so the input is never offered ready during reset.
    assign s_axi_ready = aresetn && slot_free && !insert_mode;
    assign beat_accept = s_axi_valid && s_axi_ready;
    assign marker_load = insert_mode && s_axi_valid && slot_free;

    always_comb begin
        mux_data = s_axi_data;
        mux_user = s_axi_user;
        if (insert_mode) begin
            mux_data = marker;
            mux_user = {1'b0, marker_user};
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (marker_load) begin
            state_next = ST_BODY;
        end else if (beat_accept) begin
            state_next = user_last(32'(s_axi_user), UWIDTH) ? ST_IDLE : ST_BODY;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            marker_count <= '0;
        end else if (marker_load) begin
            marker_count <= marker_count + 32'd1;
        end
    end

    // Stage p1 boundary: single registered output slot. Any pending input beat
    // (marker or payload) is offered whenever s_axi_valid is high; the slot only
    // takes it when free, which matches beat_accept / marker_load exactly.
    axi_reg_slice #(
        .WIDTH (PW)
    ) u_slot (
        .clk         (clk),
        .aresetn     (aresetn),
        .in_valid    (s_axi_valid),
        .in_payload  ({mux_data, mux_user}),
        .slot_free   (slot_free),
        .out_valid   (m_axi_valid),
        .out_payload (slot_payload),
        .out_ready   (m_axi_ready)
    );

    assign m_axi_data = slot_payload[PW-1:UWIDTH];
    assign m_axi_user = slot_payload[UWIDTH-1:0];

endmodule

// File: tb/tb_axi_marker_insert.sv
module tb_axi_marker_insert;

    localparam int DW = 64;
    localparam int UW = 9;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          is_marker;
    } exp_t;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          enable;
    logic [DW-1:0] marker;
    logic [UW-2:0] marker_user;
    logic          s_axi_valid;
    logic          s_axi_ready;
    logic [DW-1:0] s_axi_data;
    logic [UW-1:0] s_axi_user;
    logic          m_axi_valid;
    logic          m_axi_ready;
    logic [DW-1:0] m_axi_data;
    logic [UW-1:0] m_axi_user;
    logic [31:0]   marker_count;

    int     checks = 0;
    int     failures = 0;
    exp_t   sb_q[$];
    int     hs_cyc_q[$];
    int     cyc = 0;
    bit     bp_mode = 0;
    logic [DW-1:0] next_data = 64'd1;

    always #5 clk = ~clk;

    axi_marker_insert #(.DWIDTH(DW), .UWIDTH(UW)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .enable       (enable),
        .marker       (marker),
        .marker_user  (marker_user),
        .s_axi_valid  (s_axi_valid),
        .s_axi_ready  (s_axi_ready),
        .s_axi_data   (s_axi_data),
        .s_axi_user   (s_axi_user),
        .m_axi_valid  (m_axi_valid),
        .m_axi_ready  (m_axi_ready),
        .m_axi_data   (m_axi_data),
        .m_axi_user   (m_axi_user),
        .marker_count (marker_count)
    );

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: a beat transfers at the next posedge when valid&&ready
    // are seen at the negedge. Also models the receive-side detector
    // (equal = data==marker) and checks AXI hold-while-stalled.
    task automatic monitor_loop();
        exp_t          e;
        bit            held = 0;
        logic [DW-1:0] hd;
        logic [UW-1:0] hu;
        forever begin
            @(negedge clk);
            cyc++;
            if (!aresetn) begin
                held = 0;
            end else begin
                if (held) begin
                    check64("stall_hold_valid", 64'(m_axi_valid), 64'd1);
                    check64("stall_hold_data", m_axi_data, hd);
                    check64("stall_hold_user", 64'(m_axi_user), 64'(hu));
                end
                held = m_axi_valid && !m_axi_ready;
                hd = m_axi_data;
                hu = m_axi_user;
                if (m_axi_valid && m_axi_ready) begin
                    hs_cyc_q.push_back(cyc);
                    if (sb_q.size() == 0) begin
                        check64("unexpected_out_beat", m_axi_data, 64'hX);
                    end else begin
                        e = sb_q.pop_front();
                        check64("out_data", m_axi_data, e.data);
                        check64("out_user", 64'(m_axi_user), 64'(e.user));
                        check64("detector_equal", 64'(m_axi_data == marker), 64'(e.is_marker));
                    end
                end
            end
        end
    endtask

    task automatic ready_loop();
        int rc = 0;
        forever begin
            @(posedge clk);
            #1;
            m_axi_ready = bp_mode ? ((rc % 5) != 0) : 1'b1;
            rc++;
        end
    endtask

    task automatic push_marker();
        exp_t e;
        e.data = marker;
        e.user = {1'b0, marker_user};
        e.is_marker = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [UW-1:0] u);
        exp_t e;
        int   n = 0;
        e.data = d;
        e.user = u;
        e.is_marker = 1'b0;
        sb_q.push_back(e);
        s_axi_valid = 1'b1;
        s_axi_data  = d;
        s_axi_user  = u;
        forever begin
            @(negedge clk);
            if (s_axi_ready) break;
            n++;
            if (n > 1000) begin
                check64("accept_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_axi_valid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input bit en);
        logic [7:0] sb;
        enable = en;
        if (en) push_marker();
        for (int i = 0; i < len; i++) begin
            sb = 8'($urandom_range(0, 255));
            send_beat(next_data, {(i == len - 1), sb});
            next_data = next_data + 64'd1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check64("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        int s0;
        int nmk;
        aresetn     = 1'b0;
        enable      = 1'b1;
        marker      = 64'hAAAAAAAAAAAAAAAA;
        marker_user = 8'h5C;
        s_axi_valid = 1'b0;
        s_axi_data  = '0;
        s_axi_user  = '0;
        m_axi_ready = 1'b1;
        fork
            monitor_loop();
            ready_loop();
        join_none

        // Reset with input valid held high; first output must be the marker.
        push_marker();
        s_axi_valid = 1'b1;
        s_axi_data  = 64'd1;
        s_axi_user  = 9'h000;
        repeat (5) @(posedge clk);
        #1;
        check64("rst_m_valid", 64'(m_axi_valid), 64'd0);
        check64("rst_s_ready", 64'(s_axi_ready), 64'd0);
        check64("rst_count", marker_count, 64'd0);
        check64("rst_m_data", m_axi_data, 64'd0);
        check64("rst_m_user", 64'(m_axi_user), 64'd0);
        aresetn = 1'b1;

        // Basic insert: marker, 1, 2, 3, 4(last) in 5 consecutive cycles.
        s0 = hs_cyc_q.size();
        send_beat(64'd1, 9'h011);
        send_beat(64'd2, 9'h022);
        send_beat(64'd3, 9'h033);
        send_beat(64'd4, 9'h144);
        drain();
        check64("basic_count", marker_count, 64'd1);
        check64("basic_beats", 64'(hs_cyc_q.size() - s0), 64'd5);
        check64("basic_span", 64'(hs_cyc_q[hs_cyc_q.size()-1] - hs_cyc_q[s0] + 1), 64'd5);

        // Disabled: same packet, no marker and no extra cycle.
        reset_pulse();
        enable = 1'b0;
        s0 = hs_cyc_q.size();
        send_beat(64'd1, 9'h011);
        send_beat(64'd2, 9'h022);
        send_beat(64'd3, 9'h033);
        send_beat(64'd4, 9'h144);
        drain();
        check64("dis_count", marker_count, 64'd0);
        check64("dis_beats", 64'(hs_cyc_q.size() - s0), 64'd4);
        check64("dis_span", 64'(hs_cyc_q[hs_cyc_q.size()-1] - hs_cyc_q[s0] + 1), 64'd4);

        // Back-pressure: 20 random-length packets with ready low 1 cycle in 5.
        bp_mode = 1;
        next_data = 64'h100;
        s0 = hs_cyc_q.size();
        nmk = 0;
        for (int p = 0; p < 20; p++) begin
            int len;
            len = $urandom_range(1, 16);
            nmk += len + 1;
            send_pkt(len, 1'b1);
        end
        drain();
        bp_mode = 0;
        check64("bp_count", marker_count, 64'd20);
        check64("bp_beats", 64'(hs_cyc_q.size() - s0), 64'(nmk));

        // Single-beat packets back to back: 20 beats in 20 cycles.
        repeat (3) @(posedge clk);
        #1;
        s0 = hs_cyc_q.size();
        for (int p = 0; p < 10; p++) send_pkt(1, 1'b1);
        drain();
        check64("single_count", marker_count, 64'd30);
        check64("single_beats", 64'(hs_cyc_q.size() - s0), 64'd20);
        check64("single_span", 64'(hs_cyc_q[hs_cyc_q.size()-1] - hs_cyc_q[s0] + 1), 64'd20);

        // Reset mid-packet while beat 3 is offered; slot contents dropped.
        enable = 1'b1;
        push_marker();
        send_beat(64'h501, 9'h001);
        send_beat(64'h502, 9'h002);
        s_axi_valid = 1'b1;
        s_axi_data  = 64'h503;
        s_axi_user  = 9'h003;
        #2;
        aresetn = 1'b0;
        #1;
        check64("midrst_m_valid", 64'(m_axi_valid), 64'd0);
        check64("midrst_s_ready", 64'(s_axi_ready), 64'd0);
        check64("midrst_count", marker_count, 64'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        s0 = hs_cyc_q.size();
        push_marker();
        send_beat(64'h503, 9'h103);
        drain();
        check64("postrst_count", marker_count, 64'd1);
        check64("postrst_beats", 64'(hs_cyc_q.size() - s0), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "global timeout");
    end

endmodule
